inst_d: RTL
===========

// Module: inst_d
// PURPOSE
//  Instruction decode stage; consumes the fetch stage's instruction/pc stream and feeds EX.
//  Holds IF/ID register, 32x32 register file, source-hazard detection and ID/EX register.
//  Returns decode-side dest/source/write info to fetch and drives id_stall to hold fetch on RAW hazards.
//  ISA: R-type op[31:26] rs[25:21] rt[20:16] rd[15:11]; I-type op rs rt imm[15:0], dest=rt.
// PARAMETERS
//  XLEN    32  data/pc width
//  NREGS   32  register count; r0 reads 0, writes to r0 dropped
// PORTS
//  clk             in   1     clock
//  rst             in   1     synchronous, active-high reset
//  if_instruction  in   32    instruction from fetch
//  if_pc           in   32    pc of if_instruction
//  ex_flush        in   1     branch/jump taken in EX; squash IF/ID and ID/EX
//  ex_dest, ex_reg_write      in 5,1   in-flight EX destination / write enable
//  mem_dest, mem_reg_write    in 5,1   in-flight MEM destination / write enable
//  wb_en, wb_dest, wb_data    in 1,5,32  register-file write port
//  id_stall        out  1     combinational; fetch holds pc while 1
//  rs_f_id, rt_f_id, rd_f_id  out 5 each  IF/ID source/dest fields to fetch
//  id_dest, reg_write_f_id    out 5,1  decoded dest / write enable (0 if IF/ID invalid)
//  idex_valid, idex_pc, idex_opcode  out 1,32,6
//  idex_rs_val, idex_rt_val, idex_imm  out 32 each (imm sign-extended)
//  idex_dest, idex_reg_write, idex_mem_read, idex_mem_write, idex_halt  out 5,1,1,1,1
// BEHAVIOUR
//  Reset (rst=1 at posedge): IF/ID valid=0, all idex_* =0, all regs=0, state RUN.
//  Latency: IF/ID capture at edge N; ID/EX outputs valid after edge N+1.
//  Decode: op 000000-001011 even=R-type ALU (dest rd), odd=imm ALU (dest rt), reg_write=1;
//   001100 LDW dest rt, mem_read=1; 001101 STW mem_write=1, reads rt, no write;
//   001110 BZ, 001111 BEQ (reads rt), 010000 JR: no write; 010001 HALT; others = bubble.
//  Hazard: IF/ID valid and a read source (rs; rt for R-type/STW/BEQ) equals a nonzero
//   ex_dest/mem_dest with its write enable, or wb_dest with wb_en (when bypass off).
//  FSM RUN: hazard -> STALL; decoded HALT -> HALTED (idex_halt=1 for exactly one cycle).
//  FSM STALL: id_stall=1, IF/ID held, ID/EX loaded with bubble (valid=0, all enables 0);
//   hazard cleared -> RUN, held instruction issued next edge.
//  FSM HALTED: IF/ID ignored, idex_valid=0, id_stall=0; exit only via rst.
//  ex_flush beats stall and HALT decode: IF/ID valid<=0, ID/EX bubble, state->RUN (not from HALTED).
//  Regfile write at posedge when wb_en && wb_dest!=0; read combinational from IF/ID fields.
//  Reset mid-stall or mid-halt: same as power-on reset next edge.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: read of wb_dest with wb_en in same cycle returns wb_data;
//   wb stage is not a hazard source.
//  Undefined: read returns old value; wb match counts as hazard (one-cycle stall).
// TESTING
//  rst=1 two cycles -> all idex_*=0, id_stall=0, r1..r31 read 0.
//  wb r5=0x1234, then 0x00A01800 (ADD r3,r5,r0) -> idex_rs_val=0x1234, idex_dest=3, reg_write=1.
//  0x0422FFFC (ADDI r2,r1,-4) -> idex_imm=0xFFFFFFFC, idex_dest=2, idex_opcode=6'b000001.
//  ex_dest=2,ex_reg_write=1 with ADD reading r2 -> id_stall=1, idex_valid=0; release -> issues.
//  ex_flush=1 during stall -> id_stall=0 next cycle, idex_valid=0, IF/ID squashed.
//  0x44000000 (HALT) -> idex_halt=1 one cycle, then idex_valid=0 until rst.
//  (bypass) wb_en r7=0xBEEF same cycle as read r7 -> 0xBEEF with macro; stall+0xBEEF without.

Source files
------------

// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, 32-entry register file, RAW-hazard stall FSM and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback into register reads.
module inst_d #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     if_instruction,
   input  logic [XLEN-1:0] if_pc,
   input  logic            ex_flush,
   input  logic [4:0]      ex_dest,
   input  logic            ex_reg_write,
   input  logic [4:0]      mem_dest,
   input  logic            mem_reg_write,
   input  logic            wb_en,
   input  logic [4:0]      wb_dest,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_stall,
   output logic [4:0]      rs_f_id,
   output logic [4:0]      rt_f_id,
   output logic [4:0]      rd_f_id,
   output logic [4:0]      id_dest,
   output logic            reg_write_f_id,
   output logic            idex_valid,
   output logic [XLEN-1:0] idex_pc,
   output logic [5:0]      idex_opcode,
   output logic [XLEN-1:0] idex_rs_val,
   output logic [XLEN-1:0] idex_rt_val,
   output logic [XLEN-1:0] idex_imm,
   output logic [4:0]      idex_dest,
   output logic            idex_reg_write,
   output logic            idex_mem_read,
   output logic            idex_mem_write,
   output logic            idex_halt,
   output logic [1:0]      fsm_state
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state, next_state;

   logic            ifid_valid;
   logic [31:0]     ifid_instr;
   logic [XLEN-1:0] ifid_pc;

   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;

   assign op      = ifid_instr[31:26];
   assign rs      = ifid_instr[25:21];
   assign rt      = ifid_instr[20:16];
   assign rd      = ifid_instr[15:11];
   assign imm16   = ifid_instr[15:0];
   assign rs_f_id = rs;
   assign rt_f_id = rt;
   assign rd_f_id = rd;

   // Decode table; non-writing instructions report dest 0.
   logic       uses_rs, uses_rt, dec_write, dec_mem_read, dec_mem_write, dec_halt, dec_known;
   logic [4:0] dec_dest;

   always_comb begin
      uses_rs       = 1'b0;
      uses_rt       = 1'b0;
      dec_write     = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_halt      = 1'b0;
      dec_known     = 1'b1;
      dec_dest      = 5'd0;
      if (op <= 6'd11) begin
         uses_rs   = 1'b1;
         dec_write = 1'b1;
         if (op[0]) begin
            dec_dest = rt;
         end else begin
            dec_dest = rd;
            uses_rt  = 1'b1;
         end
      end else begin
         case (op)
            6'd12: begin
               uses_rs      = 1'b1;
               dec_write    = 1'b1;
               dec_mem_read = 1'b1;
               dec_dest     = rt;
            end
            6'd13: begin
               uses_rs       = 1'b1;
               uses_rt       = 1'b1;
               dec_mem_write = 1'b1;
            end
            6'd14:   uses_rs = 1'b1;
            6'd15: begin
               uses_rs = 1'b1;
               uses_rt = 1'b1;
            end
            6'd16:   uses_rs = 1'b1;
            6'd17:   dec_halt = 1'b1;
            default: dec_known = 1'b0;
         endcase
      end
   end

   assign reg_write_f_id = ifid_valid && dec_write;
   assign id_dest        = reg_write_f_id ? dec_dest : 5'd0;

   // With the bypass, writeback data is forwarded instead of being waited for.
   logic wb_haz_en;
`ifdef DECODE_WB_BYPASS_EN
   assign wb_haz_en = 1'b0;
`else
   assign wb_haz_en = wb_en;
`endif

   function automatic logic busy(input logic [4:0] src, input logic [4:0] d, input logic we);
      return we && (d != 5'd0) && (d == src);
   endfunction

   logic rs_hit, rt_hit, hazard;

   always_comb begin
      rs_hit = busy(rs, ex_dest, ex_reg_write) || busy(rs, mem_dest, mem_reg_write) ||
               busy(rs, wb_dest, wb_haz_en);
      rt_hit = busy(rt, ex_dest, ex_reg_write) || busy(rt, mem_dest, mem_reg_write) ||
               busy(rt, wb_dest, wb_haz_en);
      hazard = ifid_valid && (state != HALTED) && ((uses_rs && rs_hit) || (uses_rt && rt_hit));
   end

   // Fetch handshake: id_stall=1 means decode is not ready; fetch must hold pc and
   // instruction, IF/ID keeps its contents and ID/EX receives a bubble that cycle.
   always_comb begin
      next_state = state;
      id_stall   = 1'b0;
      case (state)
         RUN, STALL: begin
            if (ex_flush) begin
               next_state = RUN;
            end else if (hazard) begin
               next_state = STALL;
               id_stall   = 1'b1;
            end else if (ifid_valid && dec_halt) begin
               next_state = HALTED;
            end else begin
               next_state = RUN;
            end
         end
         HALTED:  next_state = HALTED;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= next_state;
   end

   assign fsm_state = state;

   logic issue;
   assign issue = ifid_valid && (state != HALTED) && !ex_flush && !hazard && dec_known;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else if (state == HALTED || next_state == HALTED || ex_flush) begin
         ifid_valid <= 1'b0;
      end else if (!hazard) begin
         ifid_valid <= 1'b1;
         ifid_instr <= if_instruction;
         ifid_pc    <= if_pc;
      end
   end

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_dest != 5'd0) begin
         regs[wb_dest] <= wb_data;
      end
   end

   logic [XLEN-1:0] rs_val, rt_val;

   always_comb begin
      rs_val = (rs == 5'd0) ? '0 : regs[rs];
      rt_val = (rt == 5'd0) ? '0 : regs[rt];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_dest != 5'd0 && wb_dest == rs) rs_val = wb_data;
      if (wb_en && wb_dest != 5'd0 && wb_dest == rt) rt_val = wb_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || !issue) begin
         idex_valid     <= 1'b0;
         idex_pc        <= '0;
         idex_opcode    <= '0;
         idex_rs_val    <= '0;
         idex_rt_val    <= '0;
         idex_imm       <= '0;
         idex_dest      <= '0;
         idex_reg_write <= 1'b0;
         idex_mem_read  <= 1'b0;
         idex_mem_write <= 1'b0;
         idex_halt      <= 1'b0;
      end else begin
         idex_valid     <= 1'b1;
         idex_pc        <= ifid_pc;
         idex_opcode    <= op;
         idex_rs_val    <= rs_val;
         idex_rt_val    <= rt_val;
         idex_imm       <= {{(XLEN-16){imm16[15]}}, imm16};
         idex_dest      <= dec_dest;
         idex_reg_write <= dec_write;
         idex_mem_read  <= dec_mem_read;
         idex_mem_write <= dec_mem_write;
         idex_halt      <= dec_halt;
      end
   end

endmodule
